// File: rtl/mod_arith_pkg.sv
// Shared constants and types for the limb-serial 256-bit modular adder/subtractor.
package mod_arith_pkg;

    localparam int LIMB_W    = 64;
    localparam int NUM_LIMBS = 4;
    localparam int WIDTH     = LIMB_W * NUM_LIMBS;
    localparam int CNT_W     = 3;

    // Counter value at which all limbs are done and the result is selected.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_LIMBS);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // SM2 prime, used as the reference modulus by the benches.
    localparam logic [WIDTH-1:0] SM2_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

endpackage

// File: rtl/mod_add_serial_if.sv
// Operand/result handshake bundle for mod_add_serial; op exists only with MOD_ADD_SUB_EN.
interface mod_add_serial_if;
    import mod_arith_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] p;
`ifdef MOD_ADD_SUB_EN
    logic             op;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;

    modport master (
        output in_valid, a, b, p,
`ifdef MOD_ADD_SUB_EN
        output op,
`endif
        output out_ready,
        input  in_ready, out_valid, res
    );

    modport slave (
        input  in_valid, a, b, p,
`ifdef MOD_ADD_SUB_EN
        input  op,
`endif
        input  out_ready,
        output in_ready, out_valid, res
    );

endinterface

// File: rtl/limb_addsub.sv
// One 64-bit limb of add-with-carry (sub = 0) or subtract-with-borrow (sub = 1).
module limb_addsub
    import mod_arith_pkg::*;
(
    input  logic [LIMB_W-1:0] x,
    input  logic [LIMB_W-1:0] y,
    input  logic              cin,
    input  logic              sub,
    output logic [LIMB_W-1:0] r,
    output logic              cout
);

    logic [LIMB_W:0] sum;

    // In subtract mode the extra top bit becomes set exactly when the result went negative.
    always_comb begin
        if (sub) begin
            sum = {1'b0, x} - {1'b0, y} - {{LIMB_W{1'b0}}, cin};
        end else begin
            sum = {1'b0, x} + {1'b0, y} + {{LIMB_W{1'b0}}, cin};
        end
    end

    assign r    = sum[LIMB_W-1:0];
    assign cout = sum[LIMB_W];

endmodule

// File: rtl/mod_add_serial.sv
// Limb-serial 256-bit (a + b) mod p; with MOD_ADD_SUB_EN defined, op = 1 selects (a - b) mod p.
module mod_add_serial
    import mod_arith_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mod_add_serial_if.slave bus
);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   a_reg, b_reg, p_reg;
    logic [WIDTH-1:0]   r1_reg, r2_reg, res_reg;
    logic               c_reg, w_reg, op_reg;
    logic               op_in;
    logic [LIMB_W-1:0]  r1, r2;
    logic               co1, co2, cin1, cin2;
    logic               use_stage2;

`ifdef MOD_ADD_SUB_EN
    assign op_in = bus.op;
`else
    assign op_in = 1'b0;
`endif

    // Add: stage1 = s (carry c), stage2 = d (borrow w). Subtract swaps the roles.
    assign cin1 = op_reg ? w_reg : c_reg;
    assign cin2 = op_reg ? c_reg : w_reg;

    limb_addsub u_stage1 (
        .x    (a_reg[LIMB_W-1:0]),
        .y    (b_reg[LIMB_W-1:0]),
        .cin  (cin1),
        .sub  (op_reg),
        .r    (r1),
        .cout (co1)
    );

    limb_addsub u_stage2 (
        .x    (r1),
        .y    (p_reg[LIMB_W-1:0]),
        .cin  (cin2),
        .sub  (~op_reg),
        .r    (r2),
        .cout (co2)
    );

    assign use_stage2 = op_reg ? w_reg : (c_reg | ~w_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid)       state_next = CALC;
            CALC:    if (cnt_reg == LAST_CNT) state_next = DONE;
            DONE:    if (bus.out_ready)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            p_reg   <= '0;
            r1_reg  <= '0;
            r2_reg  <= '0;
            res_reg <= '0;
            c_reg   <= 1'b0;
            w_reg   <= 1'b0;
            op_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg   <= bus.a;
                        b_reg   <= bus.b;
                        p_reg   <= bus.p;
                        op_reg  <= op_in;
                        cnt_reg <= '0;
                        c_reg   <= 1'b0;
                        w_reg   <= 1'b0;
                    end
                end
                CALC: begin
                    if (cnt_reg != LAST_CNT) begin
                        // Operands shift down one limb; results fill in from the top.
                        a_reg   <= {{LIMB_W{1'b0}}, a_reg[WIDTH-1:LIMB_W]};
                        b_reg   <= {{LIMB_W{1'b0}}, b_reg[WIDTH-1:LIMB_W]};
                        p_reg   <= {{LIMB_W{1'b0}}, p_reg[WIDTH-1:LIMB_W]};
                        r1_reg  <= {r1, r1_reg[WIDTH-1:LIMB_W]};
                        r2_reg  <= {r2, r2_reg[WIDTH-1:LIMB_W]};
                        c_reg   <= op_reg ? co2 : co1;
                        w_reg   <= op_reg ? co1 : co2;
                        cnt_reg <= cnt_reg + 1'b1;
                    end else begin
                        res_reg <= use_stage2 ? r2_reg : r1_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.res       = res_reg;

endmodule

// File: tb/tb_mod_add_serial.sv
// Directed-vector bench for mod_add_serial; subtract vectors run only with MOD_ADD_SUB_EN.
module tb_mod_add_serial;
    import mod_arith_pkg::*;

    localparam logic [255:0] P   = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] PM1 = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFE;
    localparam logic [255:0] PM2 = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFD;
    localparam logic [255:0] PM3 = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFC;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    mod_add_serial_if bus ();

    mod_add_serial dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [255:0] a_v, input logic [255:0] b_v,
                          input logic op_v, input logic [255:0] exp_v, input int hold);
        int cyc;
        bus.a = a_v;
        bus.b = b_v;
        bus.p = P;
`ifdef MOD_ADD_SUB_EN
        bus.op = op_v;
`endif
        bus.in_valid = 1'b1;
        check_val({tag, "_in_ready"}, {255'b0, bus.in_ready}, 256'd1);
        @(posedge clk); #1;
        // Scramble inputs during CALC; the latched operands must be used.
        bus.in_valid = 1'b0;
        bus.a = ~a_v;
        bus.b = ~b_v;
        bus.p = '0;
`ifdef MOD_ADD_SUB_EN
        bus.op = ~op_v;
`endif
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val({tag, "_latency"}, 256'(cyc), 256'd5);
        check_val({tag, "_res"}, bus.res, exp_v);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val({tag, "_hold_valid"}, {255'b0, bus.out_valid}, 256'd1);
            check_val({tag, "_hold_res"}, bus.res, exp_v);
            check_val({tag, "_hold_in_ready"}, {255'b0, bus.in_ready}, 256'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_val({tag, "_release_valid"}, {255'b0, bus.out_valid}, 256'd0);
        check_val({tag, "_release_in_ready"}, {255'b0, bus.in_ready}, 256'd1);
        $display("[TB] %s op=%0d latency=%0d res=%h exp=%h", tag, op_v, cyc, bus.res, exp_v);
    endtask

    initial begin
        int valid_seen;
        tests_run    = 0;
        tests_failed = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.p = '0;
`ifdef MOD_ADD_SUB_EN
        bus.op = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_in_ready", {255'b0, bus.in_ready}, 256'd1);
        check_val("reset_out_valid", {255'b0, bus.out_valid}, 256'd0);
        check_val("reset_res", bus.res, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add_1_2",       256'd1, 256'd2, 1'b0, 256'd3, 0);
        run_op("add_wrap_zero", PM1, 256'd1, 1'b0, 256'd0, 0);
        run_op("add_carry256",  PM1, PM1, 1'b0, PM2, 0);
        run_op("add_limb_carry", 256'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 256'd1, 1'b0,
               256'h1_0000_0000_0000_0000, 0);
        run_op("add_pm1_2",     PM1, 256'd2, 1'b0, 256'd1, 0);
        run_op("add_zero",      256'd0, 256'd0, 1'b0, 256'd0, 0);
        run_op("add_hold",      256'd7, 256'd9, 1'b0, 256'd16, 3);

        // Reset pulsed in the second CALC cycle abandons the operation.
        bus.a = 256'd1;
        bus.b = 256'd2;
        bus.p = P;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_val("rst_calc_out_valid", {255'b0, bus.out_valid}, 256'd0);
        check_val("rst_calc_in_ready", {255'b0, bus.in_ready}, 256'd1);
        check_val("rst_calc_res", bus.res, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) valid_seen++;
        end
        check_val("rst_calc_no_output", 256'(valid_seen), 256'd0);
        $display("[TB] reset during CALC: out_valid cycles after release=%0d", valid_seen);
        run_op("add_after_rst", 256'd10, 256'd20, 1'b0, 256'd30, 0);

`ifdef MOD_ADD_SUB_EN
        run_op("sub_2_5",   256'd2, 256'd5, 1'b1, PM3, 0);
        run_op("sub_5_2",   256'd5, 256'd2, 1'b1, 256'd3, 0);
        run_op("sub_0_pm1", 256'd0, PM1, 1'b1, 256'd1, 0);
        run_op("sub_pm1_0", PM1, 256'd0, 1'b1, PM1, 0);
        run_op("add_mixed", 256'd4, 256'd5, 1'b0, 256'd9, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
